syncfifo_write_ctrl: RTL
========================

# syncfifo_write_ctrl

Write-side controller for the synchronous FIFO, the companion to the read-pointer block. It owns the write pointer and accepts writes only when the FIFO has space. It also generates full, occupancy, a hysteretic almost-full flow-control flag and a sticky overflow flag. It sits between the upstream producer and the FIFO storage array, and exchanges pointers with the read-side block in the same clock domain.

## Interface
- `depth`, 16: number of FIFO entries; must be a power of two, ≥ 2.
- `ptr_width`, `$clog2(depth)+1`: pointer width, including the wrap bit.
- `afull_hi`, `depth-4`: occupancy at or above which `almost_full` asserts; 1 ≤ `afull_hi` ≤ `depth`.
- `afull_lo`, `depth/4`: occupancy at or below which `almost_full` deasserts; `afull_lo` < `afull_hi`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wen`  in  1  producer write request.
- `r_ptr`  in  ptr_width  read pointer from the read-side block (registered there).
- `w_ptr`  out  ptr_width  write pointer to the read-side block.
- `waddr`  out  ptr_width-1  storage write address, equal to `w_ptr[ptr_width-2:0]`.
- `mem_we`  out  1  storage write enable, equal to `wen & ~full`.
- `full`  out  1  FIFO full.
- `count`  out  ptr_width  occupancy, range 0..depth.
- `almost_full`  out  1  hysteretic near-full flag (registered).
- `clr_ovf`  in  1  clears `overflow` (present only when the overflow feature is compiled in).
- `overflow`  out  1  sticky overflow flag (present only when the overflow feature is compiled in).

## Operation
- Write acceptance: `accept = wen & ~full`.
  - On the next edge, `w_ptr <= w_ptr + accept`, with modulo 2^ptr_width wrap.
  - A write to a full FIFO is dropped: `w_ptr` does not move and `mem_we` stays 0.
- `full` = (`w_ptr[msb] != r_ptr[msb]`) and (`w_ptr[msb-1:0] == r_ptr[msb-1:0]`). Combinational.
- `count` = `w_ptr - r_ptr`, computed in ptr_width bits modulo 2^ptr_width. It is correct across pointer wrap. `count == depth` if and only if `full`.
- `almost_full` is a 2-state FSM:
  - BELOW (output 0) → ABOVE when `count >= afull_hi`.
  - ABOVE (output 1) → BELOW when `count <= afull_lo`.
  - Otherwise the FSM holds its state.
- `overflow`:
  - Set on any edge where `wen & full`.
  - Cleared by `clr_ovf`.
  - If set and clear occur in the same cycle, set wins.
- Reads are not observed directly. Space freed by a read appears only through `r_ptr`.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `w_ptr`=0, `almost_full`=0 (FSM in BELOW), `overflow`=0.
  - With `r_ptr`=0 this gives `full`=0 and `count`=0.
- Write latency: an accepted `wen` in cycle N advances `w_ptr` and `count` in cycle N+1.
- `full` and `mem_we` are combinational from registered pointers plus `wen`. There is no combinational path from `wen` to `full`.
- `almost_full` lags `count` by one cycle, because the FSM samples the current `count`.
- Full and read in the same cycle: the write is still rejected in that cycle. Space becomes visible in the cycle after the read-side `r_ptr` advances.
- Reset mid-operation: all state clears immediately. The read side must also be reset so that the pointers agree.
- Deassertion of `rst_n` takes effect from the first subsequent rising edge. Synchronous release of `rst_n` is the integrator's responsibility.

## Configuration
- `SYNCFIFO_WRITECTRL_OVERFLOW_EN`:
  - Defined: the `clr_ovf` and `overflow` ports and the sticky register exist as described above.
  - Undefined: both ports are absent, the register is not built, and writes to a full FIFO are silently dropped.
  - All other behaviour is identical in both builds.

## Test plan
All scenarios use `depth`=16, `afull_hi`=12, `afull_lo`=4, with a model read pointer driving `r_ptr`.
- Reset, then 16 consecutive `wen` with no reads → `w_ptr` 0→16, `waddr` wraps 15→0, `count`=16, `full`=1 after the 16th edge, `mem_we`=0 thereafter.
- Write when full (`wen`=1, `r_ptr` held) → `w_ptr` stays 16, `overflow`=1 and stays 1 after `wen` drops.
  - `clr_ovf` pulse → 0.
  - `clr_ovf` together with `wen` while full → stays 1.
- Fill to 12 → `almost_full`=1 one cycle after `count`=12.
- Drain to 5 → still 1. At 4 → `almost_full`=0 on the following cycle.
- Wrap: run 40 writes with interleaved reads keeping `count` at 3 → `w_ptr` passes 31→0, `count` is always 3, `full` never asserts.
- Assert `rst_n`=0 mid-burst at `count`=9, between clock edges → `w_ptr`, `count`, `almost_full`, `overflow` all 0 before the next edge.
- Build without `SYNCFIFO_WRITECTRL_OVERFLOW_EN`, then repeat the first and third scenarios → identical pointer, `full`, `count` and `almost_full` results.

Source files
------------

// File: rtl/syncfifo_write_ctrl.sv
// Write-side FIFO controller: write pointer, full, occupancy and hysteretic almost_full.
// Define SYNCFIFO_WRITECTRL_OVERFLOW_EN to build the sticky overflow flag and its clear input.
module syncfifo_write_ctrl #(
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = $clog2(DEPTH) + 1,
  parameter int AFULL_HI  = DEPTH - 4,
  parameter int AFULL_LO  = DEPTH / 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wen,
  input  logic [PTR_WIDTH-1:0] i_r_ptr,
`ifdef SYNCFIFO_WRITECTRL_OVERFLOW_EN
  input  logic                 i_clr_ovf,
  output logic                 o_overflow,
`endif
  output logic [PTR_WIDTH-1:0] o_w_ptr,
  output logic [PTR_WIDTH-2:0] o_waddr,
  output logic                 o_mem_we,
  output logic                 o_full,
  output logic [PTR_WIDTH-1:0] o_count,
  output logic                 o_almost_full
);

  // state    | meaning
  // ST_BELOW | almost_full = 0, waiting for count >= AFULL_HI
  // ST_ABOVE | almost_full = 1, waiting for count <= AFULL_LO
  typedef enum logic {
    ST_BELOW = 1'b0,
    ST_ABOVE = 1'b1
  } af_state_t;

  localparam logic [PTR_WIDTH-1:0] LP_AF_HI = PTR_WIDTH'(AFULL_HI);
  localparam logic [PTR_WIDTH-1:0] LP_AF_LO = PTR_WIDTH'(AFULL_LO);

  logic [PTR_WIDTH-1:0] r_w_ptr;
  af_state_t            r_af_state;
  af_state_t            w_af_next;
  logic                 w_full;
  logic                 w_accept;
  logic [PTR_WIDTH-1:0] w_count;

  // Same index with opposite wrap bits means the writer is a full lap ahead.
  assign w_full   = (r_w_ptr[PTR_WIDTH-1] != i_r_ptr[PTR_WIDTH-1]) &&
                    (r_w_ptr[PTR_WIDTH-2:0] == i_r_ptr[PTR_WIDTH-2:0]);
  assign w_accept = i_wen & ~w_full;
  assign w_count  = r_w_ptr - i_r_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_w_ptr <= '0;
    end else begin
      r_w_ptr <= r_w_ptr + {{(PTR_WIDTH-1){1'b0}}, w_accept};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_af_state <= ST_BELOW;
    end else begin
      r_af_state <= w_af_next;
    end
  end

  always_comb begin
    w_af_next = r_af_state;
    case (r_af_state)
      ST_BELOW: if (w_count >= LP_AF_HI) w_af_next = ST_ABOVE;
      ST_ABOVE: if (w_count <= LP_AF_LO) w_af_next = ST_BELOW;
      default:  w_af_next = ST_BELOW;
    endcase
  end

`ifdef SYNCFIFO_WRITECTRL_OVERFLOW_EN
  logic r_overflow;

  // A rejected write in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
    end else if (i_wen & w_full) begin
      r_overflow <= 1'b1;
    end else if (i_clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign o_overflow = r_overflow;
`endif

  assign o_w_ptr       = r_w_ptr;
  assign o_waddr       = r_w_ptr[PTR_WIDTH-2:0];
  assign o_mem_we      = w_accept;
  assign o_full        = w_full;
  assign o_count       = w_count;
  assign o_almost_full = (r_af_state == ST_ABOVE);

endmodule
